// File: rtl/uart_word_pkg.sv
// Shared constants and TX state encoding for the UART word controller.
package uart_word_pkg;
    localparam int DEF_WORD_BYTES     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 100000;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_LOAD = 2'd1,
        T_GAP  = 2'd2,
        T_BUSY = 2'd3
    } tx_state_e;
endpackage

// File: rtl/uart_word_ctrl_tx.sv
// TX path: serialises a latched word MSB-first into single UART byte strobes.
module uart_word_tx
    import uart_word_pkg::*;
#(
    parameter int WORD_BYTES = DEF_WORD_BYTES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*WORD_BYTES-1:0] word_in,
    input  logic                    word_in_valid,
    output logic                    word_in_ready,
    output logic [7:0]              tx_byte,
    output logic                    tx_en,
    input  logic                    tx_busy
);
    localparam int W = 8 * WORD_BYTES;
    localparam logic [3:0] LAST_IDX = 4'(WORD_BYTES - 1);

    tx_state_e    state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [W-1:0] word_q, word_d;
    logic [W-1:0] word_shl;
    logic [7:0]   byte_q, byte_d;
    logic         en_q, en_d;
    logic         rdy_q, rdy_d;

    assign word_shl = word_q << {idx_q, 3'b000};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        byte_d  = byte_q;
        en_d    = 1'b0;
        case (state_q)
            T_IDLE: begin
                if (rdy_q && word_in_valid) begin
                    word_d  = word_in;
                    idx_d   = '0;
                    state_d = T_LOAD;
                end
            end
            T_LOAD: begin
                if (!tx_busy) begin
                    byte_d  = word_shl[W-1 -: 8];
                    en_d    = 1'b1;
                    state_d = T_GAP;
                end
            end
            // Guard cycle lets the UART raise tx_busy before it is sampled.
            T_GAP:  state_d = T_BUSY;
            T_BUSY: begin
                if (!tx_busy) begin
                    idx_d   = idx_q + 4'd1;
                    state_d = (idx_q == LAST_IDX) ? T_IDLE : T_LOAD;
                end
            end
            default: state_d = T_IDLE;
        endcase
        rdy_d = (state_d == T_IDLE);
    end

    always_ff @(posedge clk) begin
        word_q <= word_d;
        if (rst) begin
            state_q <= T_IDLE;
            idx_q   <= '0;
            byte_q  <= '0;
            en_q    <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            en_q    <= en_d;
            rdy_q   <= rdy_d;
        end
    end

    assign word_in_ready = rdy_q;
    assign tx_byte       = byte_q;
    assign tx_en         = en_q;
endmodule

// File: rtl/uart_word_ctrl.sv
// UART word controller: assembles RX bytes into words and hands TX words to the byte serialiser.
module uart_word_ctrl
    import uart_word_pkg::*;
#(
    parameter int WORD_BYTES     = DEF_WORD_BYTES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_byte_valid,
    input  logic [7:0]              rx_byte,
    output logic [8*WORD_BYTES-1:0] word_out,
    output logic                    word_out_valid,
    input  logic                    word_out_ready,
    input  logic [8*WORD_BYTES-1:0] word_in,
    input  logic                    word_in_valid,
    output logic                    word_in_ready,
    output logic [7:0]              tx_byte,
    output logic                    tx_en,
    input  logic                    tx_busy,
    output logic                    rx_overrun,
    output logic                    rx_timeout,
    output logic [3:0]              rx_byte_cnt
);
    localparam int W    = 8 * WORD_BYTES;
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]      LAST_IDX = 4'(WORD_BYTES - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0]    sr_q, sr_d;
    logic [W-1:0]    word_q, word_d;
    logic            word_vld_q, word_vld_d;
    logic            ovr_q, ovr_d;
    logic            tmo_q, tmo_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            word_done;

    always_comb begin
        sr_d       = sr_q;
        word_d     = word_q;
        word_vld_d = word_vld_q;
        cnt_d      = cnt_q;
        to_d       = to_q;
        ovr_d      = 1'b0;
        tmo_d      = 1'b0;
        word_done  = rx_byte_valid && (cnt_q == LAST_IDX);
        if (word_vld_q && word_out_ready)
            word_vld_d = 1'b0;
        // A byte always beats a timeout expiring on the same cycle.
        if (rx_byte_valid) begin
            sr_d  = {sr_q[W-9:0], rx_byte};
            to_d  = '0;
            cnt_d = cnt_q + 4'd1;
            if (word_done) begin
                cnt_d = '0;
                if (word_vld_q && !word_out_ready) begin
                    ovr_d = 1'b1;
                end else begin
                    word_d     = sr_d;
                    word_vld_d = 1'b1;
                end
            end
        end else if (cnt_q != '0) begin
            if (to_q == TO_LAST) begin
                cnt_d = '0;
                to_d  = '0;
                tmo_d = 1'b1;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        sr_q <= sr_d;
        if (rst) begin
            word_q     <= '0;
            word_vld_q <= 1'b0;
            cnt_q      <= '0;
            to_q       <= '0;
            ovr_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            ovr_q      <= ovr_d;
            tmo_q      <= tmo_d;
        end
    end

    assign word_out       = word_q;
    assign word_out_valid = word_vld_q;
    assign rx_overrun     = ovr_q;
    assign rx_timeout     = tmo_q;
    assign rx_byte_cnt    = cnt_q;

    uart_word_tx #(
        .WORD_BYTES(WORD_BYTES)
    ) u_tx (
        .clk          (clk),
        .rst          (rst),
        .word_in      (word_in),
        .word_in_valid(word_in_valid),
        .word_in_ready(word_in_ready),
        .tx_byte      (tx_byte),
        .tx_en        (tx_en),
        .tx_busy      (tx_busy)
    );
endmodule
